// File: rtl/mc8051_agu.sv
// mc8051 address-generation unit: turns one addressing request per handshake into
// a registered {address, space, bit index, error} entry and owns the stack pointer.
module mc8051_agu #(
  parameter int unsigned ADDR_W      = 16,
  parameter logic [7:0]  SP_RESET    = 8'h07,
  parameter int unsigned BANK_STRIDE = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [3:0]        i_mode,
  input  logic [1:0]        i_rs,
  input  logic [2:0]        i_rn,
  input  logic [7:0]        i_base_h,
  input  logic [7:0]        i_base_l,
  input  logic [7:0]        i_offset,
  input  logic [15:0]       i_pc,
  input  logic [7:0]        i_direct,
  input  logic              i_sp_wr,
  input  logic [7:0]        i_sp_wdata,
  output logic              o_addr_valid,
  input  logic              i_addr_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_space,
  output logic [2:0]        o_bit_idx,
  output logic              o_err,
  output logic [7:0]        o_sp_q
);

  localparam logic [3:0] MODE_REG       = 4'd0;
  localparam logic [3:0] MODE_DIRECT    = 4'd1;
  localparam logic [3:0] MODE_IND8      = 4'd2;
  localparam logic [3:0] MODE_XDPTR     = 4'd3;
  localparam logic [3:0] MODE_XRI       = 4'd4;
  localparam logic [3:0] MODE_CODE_DPTR = 4'd5;
  localparam logic [3:0] MODE_CODE_PC   = 4'd6;
  localparam logic [3:0] MODE_BIT       = 4'd7;
  localparam logic [3:0] MODE_PUSH      = 4'd8;
  localparam logic [3:0] MODE_POP       = 4'd9;

  localparam logic [1:0] SPACE_IRAM  = 2'd0;
  localparam logic [1:0] SPACE_SFR   = 2'd1;
  localparam logic [1:0] SPACE_XDATA = 2'd2;
  localparam logic [1:0] SPACE_CODE  = 2'd3;

  logic [7:0]  sp_q;
  logic        accept;
  logic        take;
  logic [15:0] bank_base;
  logic [15:0] dptr_sum;
  logic [15:0] pc_sum;
  logic [7:0]  bit_byte;
  logic [7:0]  sp_inc;
  logic [7:0]  sp_dec;
  logic [15:0] calc_addr;
  logic [1:0]  calc_space;
  logic [2:0]  calc_bit;
  logic        calc_err;

  // Handshake: a request transfers on a rising edge where i_req_valid && o_req_ready;
  // the entry transfers where o_addr_valid && i_addr_ready. Producers hold their
  // payload stable while valid is high and not yet taken.
  assign o_req_ready = !o_addr_valid || i_addr_ready;
  assign accept      = i_req_valid && o_req_ready;
  assign take        = o_addr_valid && i_addr_ready;

  assign bank_base = 16'(i_rs) * 16'(BANK_STRIDE) + 16'(i_rn);
  assign dptr_sum  = {i_base_h, i_base_l} + {8'h00, i_offset};
  assign pc_sum    = i_pc + {8'h00, i_offset};
  assign bit_byte  = 8'h20 + {4'h0, i_direct[6:3]};
  assign sp_inc    = sp_q + 8'd1;
  assign sp_dec    = sp_q - 8'd1;

  always_comb begin
    calc_addr  = 16'h0000;
    calc_space = SPACE_IRAM;
    calc_bit   = 3'd0;
    calc_err   = 1'b0;
    case (i_mode)
      MODE_REG: begin
        calc_addr = bank_base;
      end
      MODE_DIRECT: begin
        calc_addr  = {8'h00, i_direct};
        calc_space = i_direct[7] ? SPACE_SFR : SPACE_IRAM;
      end
      MODE_IND8: begin
        calc_addr = {8'h00, i_base_l};
      end
      MODE_XDPTR: begin
        calc_addr  = {i_base_h, i_base_l};
        calc_space = SPACE_XDATA;
      end
      MODE_XRI: begin
        calc_addr  = {8'h00, i_base_l};
        calc_space = SPACE_XDATA;
      end
      MODE_CODE_DPTR: begin
        calc_addr  = dptr_sum;
        calc_space = SPACE_CODE;
      end
      MODE_CODE_PC: begin
        calc_addr  = pc_sum;
        calc_space = SPACE_CODE;
      end
      MODE_BIT: begin
        // Low half of the bit space lives in RAM bytes 20h-2Fh; the upper half maps
        // onto the bit-addressable SFRs, which sit on 8-byte boundaries.
        calc_bit = i_direct[2:0];
        if (i_direct[7]) begin
          calc_addr  = {8'h00, i_direct[7:3], 3'b000};
          calc_space = SPACE_SFR;
        end else begin
          calc_addr = {8'h00, bit_byte};
        end
      end
      MODE_PUSH: begin
        calc_addr = {8'h00, sp_inc};
      end
      MODE_POP: begin
        calc_addr = {8'h00, sp_q};
      end
      default: begin
        calc_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_addr_valid <= 1'b0;
      o_addr       <= '0;
      o_space      <= SPACE_IRAM;
      o_bit_idx    <= 3'd0;
      o_err        <= 1'b0;
    end else if (accept) begin
      o_addr_valid <= 1'b1;
      o_addr       <= ADDR_W'(calc_addr);
      o_space      <= calc_space;
      o_bit_idx    <= calc_bit;
      o_err        <= calc_err;
    end else if (take) begin
      o_addr_valid <= 1'b0;
    end
  end

  // A software write beats a concurrent PUSH/POP; the request still used the old SP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sp_q <= SP_RESET;
    end else if (i_sp_wr) begin
      sp_q <= i_sp_wdata;
    end else if (accept && (i_mode == MODE_PUSH)) begin
      sp_q <= sp_inc;
    end else if (accept && (i_mode == MODE_POP)) begin
      sp_q <= sp_dec;
    end
  end

  assign o_sp_q = sp_q;

endmodule

// File: tb/tb_mc8051_agu.sv
// Bench for mc8051_agu: directed addressing cases plus random traffic, checked
// through an expected-entry queue and a bench-side stack pointer model.
module tb_mc8051_agu;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [3:0]  i_mode;
  logic [1:0]  i_rs;
  logic [2:0]  i_rn;
  logic [7:0]  i_base_h;
  logic [7:0]  i_base_l;
  logic [7:0]  i_offset;
  logic [15:0] i_pc;
  logic [7:0]  i_direct;
  logic        i_sp_wr;
  logic [7:0]  i_sp_wdata;
  logic        o_addr_valid;
  logic        i_addr_ready;
  logic [15:0] o_addr;
  logic [1:0]  o_space;
  logic [2:0]  o_bit_idx;
  logic        o_err;
  logic [7:0]  o_sp_q;

  mc8051_agu #(.ADDR_W(16), .SP_RESET(8'h07), .BANK_STRIDE(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_mode(i_mode), .i_rs(i_rs), .i_rn(i_rn), .i_base_h(i_base_h), .i_base_l(i_base_l),
    .i_offset(i_offset), .i_pc(i_pc), .i_direct(i_direct), .i_sp_wr(i_sp_wr),
    .i_sp_wdata(i_sp_wdata), .o_addr_valid(o_addr_valid), .i_addr_ready(i_addr_ready),
    .o_addr(o_addr), .o_space(o_space), .o_bit_idx(o_bit_idx), .o_err(o_err),
    .o_sp_q(o_sp_q)
  );

  always #5 i_clk = ~i_clk;

  logic [21:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        mv;
  logic [7:0]  sp_m;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [21:0] mk(input logic [15:0] a, input logic [1:0] s,
                                     input logic [2:0] b, input logic e);
    return {a, s, b, e};
  endfunction

  // Reference model of one request, written from the addressing-mode table.
  function automatic logic [21:0] model(input logic [7:0] sp);
    case (i_mode)
      4'd0: return mk(16'(i_rs) * 16'd8 + 16'(i_rn), 2'd0, 3'd0, 1'b0);
      4'd1: return mk({8'h00, i_direct}, (i_direct >= 8'h80) ? 2'd1 : 2'd0, 3'd0, 1'b0);
      4'd2: return mk({8'h00, i_base_l}, 2'd0, 3'd0, 1'b0);
      4'd3: return mk({i_base_h, i_base_l}, 2'd2, 3'd0, 1'b0);
      4'd4: return mk({8'h00, i_base_l}, 2'd2, 3'd0, 1'b0);
      4'd5: return mk({i_base_h, i_base_l} + 16'(i_offset), 2'd3, 3'd0, 1'b0);
      4'd6: return mk(i_pc + 16'(i_offset), 2'd3, 3'd0, 1'b0);
      4'd7: begin
        if (i_direct < 8'h80) return mk(16'h0020 + 16'(i_direct / 8), 2'd0, i_direct % 8, 1'b0);
        else return mk(16'(i_direct & 8'hF8), 2'd1, i_direct % 8, 1'b0);
      end
      4'd8: return mk(16'(8'(sp + 8'd1)), 2'd0, 3'd0, 1'b0);
      4'd9: return mk(16'(sp), 2'd0, 3'd0, 1'b0);
      default: return mk(16'h0000, 2'd0, 3'd0, 1'b1);
    endcase
  endfunction

  task automatic idle();
    i_req_valid = 1'b0; i_mode = 4'd0; i_rs = 2'd0; i_rn = 3'd0;
    i_base_h = 8'h00; i_base_l = 8'h00; i_offset = 8'h00; i_pc = 16'h0000;
    i_direct = 8'h00; i_sp_wr = 1'b0; i_sp_wdata = 8'h00; i_addr_ready = 1'b1;
  endtask

  task automatic request(input logic [3:0] mode);
    idle();
    i_req_valid = 1'b1;
    i_mode      = mode;
  endtask

  // One clock: checks pre-edge outputs against the model, advances the model, clocks.
  task automatic tick(input logic [21:0] exp);
    logic acc;
    #1;
    check("req_ready", 32'(o_req_ready), 32'(!mv || i_addr_ready));
    check("addr_valid", 32'(o_addr_valid), 32'(mv));
    if (mv) begin
      if (exp_q.size() == 0) begin
        check("queue_depth", exp_q.size(), 1);
      end else begin
        check("entry", 32'({o_addr, o_space, o_bit_idx, o_err}), 32'(exp_q[0]));
        if (i_addr_ready) void'(exp_q.pop_front());
      end
    end
    acc = !i_rst && i_req_valid && (!mv || i_addr_ready);
    if (i_rst) begin
      mv   = 1'b0;
      sp_m = 8'h07;
      exp_q.delete();
    end else begin
      if (acc) exp_q.push_back(exp);
      if (i_sp_wr) sp_m = i_sp_wdata;
      else if (acc && i_mode == 4'd8) sp_m = sp_m + 8'd1;
      else if (acc && i_mode == 4'd9) sp_m = sp_m - 8'd1;
      if (acc) mv = 1'b1;
      else if (i_addr_ready) mv = 1'b0;
    end
    @(posedge i_clk);
    #1;
    check("sp_model", 32'(o_sp_q), 32'(sp_m));
  endtask

  initial begin
    idle();
    i_rst = 1'b1;
    mv    = 1'b0;
    sp_m  = 8'h07;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", 32'(o_addr_valid), 0);
    check("rst_sp", 32'(o_sp_q), 32'h07);
    check("rst_entry", 32'({o_addr, o_space, o_bit_idx, o_err}), 0);
    i_rst = 1'b0;

    request(4'd0); i_rs = 2'd2; i_rn = 3'd5; tick(mk(16'h0015, 2'd0, 3'd0, 1'b0));
    request(4'd8); tick(mk(16'h0008, 2'd0, 3'd0, 1'b0));
    request(4'd8); tick(mk(16'h0009, 2'd0, 3'd0, 1'b0));
    request(4'd8); tick(mk(16'h000A, 2'd0, 3'd0, 1'b0));
    check("sp_push3", 32'(o_sp_q), 32'h0A);
    request(4'd9); tick(mk(16'h000A, 2'd0, 3'd0, 1'b0));
    check("sp_pop", 32'(o_sp_q), 32'h09);

    request(4'd5); i_base_h = 8'hFF; i_base_l = 8'hF0; i_offset = 8'h20;
    tick(mk(16'h0010, 2'd3, 3'd0, 1'b0));
    idle(); i_sp_wr = 1'b1; i_sp_wdata = 8'hFF; tick(22'h0);
    request(4'd8); tick(mk(16'h0000, 2'd0, 3'd0, 1'b0));
    check("sp_wrap", 32'(o_sp_q), 32'h00);

    request(4'd7); i_direct = 8'h2B; tick(mk(16'h0025, 2'd0, 3'd3, 1'b0));
    request(4'd7); i_direct = 8'hD7; tick(mk(16'h00D0, 2'd1, 3'd7, 1'b0));

    // Backpressure: the BIT entry is pending and the consumer stalls.
    for (int i = 0; i < 3; i++) begin
      request(4'd8); i_addr_ready = 1'b0;
      #1;
      check("bp_req_ready", 32'(o_req_ready), 0);
      tick(mk(16'h0001, 2'd0, 3'd0, 1'b0));
      check("bp_sp", 32'(o_sp_q), 32'h00);
    end
    request(4'd8); tick(mk(16'h0001, 2'd0, 3'd0, 1'b0));
    idle(); tick(22'h0);
    check("bp_sp_once", 32'(o_sp_q), 32'h01);

    idle(); i_sp_wr = 1'b1; i_sp_wdata = 8'h30; tick(22'h0);
    request(4'd9); i_sp_wr = 1'b1; i_sp_wdata = 8'h50; tick(mk(16'h0030, 2'd0, 3'd0, 1'b0));
    check("sp_collide", 32'(o_sp_q), 32'h50);
    request(4'd12); tick(mk(16'h0000, 2'd0, 3'd0, 1'b1));
    check("sp_illegal", 32'(o_sp_q), 32'h50);

    request(4'd0); i_rs = 2'd3; i_rn = 3'd7; tick(mk(16'h001F, 2'd0, 3'd0, 1'b0));
    request(4'd1); i_direct = 8'h85; tick(mk(16'h0085, 2'd1, 3'd0, 1'b0));
    request(4'd1); i_direct = 8'h42; tick(mk(16'h0042, 2'd0, 3'd0, 1'b0));
    request(4'd2); i_base_l = 8'h9C; i_base_h = 8'h55; tick(mk(16'h009C, 2'd0, 3'd0, 1'b0));
    request(4'd3); i_base_h = 8'h12; i_base_l = 8'h34; tick(mk(16'h1234, 2'd2, 3'd0, 1'b0));
    request(4'd4); i_base_h = 8'hEE; i_base_l = 8'h77; tick(mk(16'h0077, 2'd2, 3'd0, 1'b0));
    request(4'd6); i_pc = 16'hFFFF; i_offset = 8'h01; tick(mk(16'h0000, 2'd3, 3'd0, 1'b0));
    request(4'd15); tick(mk(16'h0000, 2'd0, 3'd0, 1'b1));
    idle(); tick(22'h0);

    for (int n = 0; n < 400; n++) begin
      idle();
      i_req_valid  = ($urandom_range(0, 3) != 0);
      i_mode       = 4'($urandom_range(0, 15));
      i_rs         = 2'($urandom_range(0, 3));
      i_rn         = 3'($urandom_range(0, 7));
      i_base_h     = 8'($urandom_range(0, 255));
      i_base_l     = 8'($urandom_range(0, 255));
      i_offset     = 8'($urandom_range(0, 255));
      i_pc         = 16'($urandom_range(0, 65535));
      i_direct     = 8'($urandom_range(0, 255));
      i_sp_wr      = ($urandom_range(0, 9) == 0);
      i_sp_wdata   = 8'($urandom_range(0, 255));
      i_addr_ready = ($urandom_range(0, 3) != 0);
      tick(model(sp_m));
    end
    idle(); tick(22'h0);

    // Reset while an entry is pending and a request plus SP write are presented.
    request(4'd3); i_base_h = 8'hAB; i_base_l = 8'hCD; i_addr_ready = 1'b0;
    tick(mk(16'hABCD, 2'd2, 3'd0, 1'b0));
    request(4'd8); i_addr_ready = 1'b0; i_sp_wr = 1'b1; i_sp_wdata = 8'h99; i_rst = 1'b1;
    tick(22'h0);
    check("midrst_valid", 32'(o_addr_valid), 0);
    check("midrst_sp", 32'(o_sp_q), 32'h07);
    i_rst = 1'b0;
    idle(); tick(22'h0);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc8051_agu.md
Name: mc8051_agu

Overview:
- Registered, parametrised address-generation unit for the mc8051 core. Successor to the combinational stage-address muxing.
- Converts one addressing request per handshake into a memory address, address space tag and bit index.
- Owns the stack pointer (SP), with automatic pre-increment on PUSH and post-decrement on POP.
- Sits between the decoder/sequencer and the memory interface, with a one-entry output register and valid/ready flow control.

Parameters:
- ADDR_W, 16: output address width, must be >= 16; narrower results are zero-extended.
- SP_RESET, 8'h07: SP value after reset.
- BANK_STRIDE, 8: bytes per register bank; must be a power of two, >= 8.

Ports:
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_rst  in  1  reset, synchronous and active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  AGU can accept a request this cycle.
- i_mode  in  4  addressing mode (encoding below).
- i_rs  in  2  register-bank select {RS1,RS0}.
- i_rn  in  3  register number Rn.
- i_base_h  in  8  high base byte (DPH).
- i_base_l  in  8  low base byte (DPL, or Ri contents for @Ri).
- i_offset  in  8  unsigned offset (accumulator).
- i_pc  in  16  current program counter.
- i_direct  in  8  direct address or bit address.
- i_sp_wr  in  1  software write to SP.
- i_sp_wdata  in  8  SP write value.
- o_addr_valid  out  1  output entry valid.
- i_addr_ready  in  1  consumer takes the entry.
- o_addr  out  ADDR_W  generated address.
- o_space  out  2  address space: 0 internal RAM, 1 SFR, 2 XDATA, 3 CODE.
- o_bit_idx  out  3  bit position for bit modes, else 0.
- o_err  out  1  entry was produced from an illegal mode.
- o_sp_q  out  8  current SP.

Behaviour:
- Reset values (i_rst high at a clock edge): o_addr_valid=0, o_addr=0, o_space=0, o_bit_idx=0, o_err=0, SP=SP_RESET. Reset overrides any accept or SP write in that cycle, including mid-transfer; a pending entry is dropped.
- Ready: o_req_ready = !o_addr_valid || i_addr_ready (combinational, one-entry pipeline, full throughput).
- Accept: occurs when i_req_valid && o_req_ready. Output fields load on that edge, giving 1-cycle latency; o_addr_valid is set.
- Drain: if the consumer takes the entry (o_addr_valid && i_addr_ready) and no new accept occurs in that cycle, o_addr_valid clears.
- Hold: while o_addr_valid && !i_addr_ready, all outputs stay stable.
- Mode encoding (all sums wrap modulo 2^16, then zero-extend to ADDR_W):
  - 0 REG: i_rs*BANK_STRIDE + i_rn; space 0.
  - 1 DIRECT: {0,i_direct}; space 1 if i_direct[7]=1, else 0.
  - 2 IND8 (@Ri): {0,i_base_l}; space 0.
  - 3 XDPTR (MOVX @DPTR): {i_base_h,i_base_l}; space 2.
  - 4 XRI (MOVX @Ri): {0,i_base_l}; space 2.
  - 5 CODE_DPTR (@A+DPTR): {i_base_h,i_base_l}+i_offset; space 3.
  - 6 CODE_PC (@A+PC): i_pc+i_offset; space 3.
  - 7 BIT: if i_direct<8'h80, address 8'h20+i_direct[6:3] in space 0; else {i_direct[7:3],3'b000} in space 1. o_bit_idx=i_direct[2:0].
  - 8 PUSH: address SP+1 (8-bit wrap); space 0; SP becomes SP+1 on accept.
  - 9 POP: address SP; space 0; SP becomes SP-1 (8-bit wrap) on accept.
  - 10-15 illegal: address 0, space 0, o_err=1. SP is unchanged.
- o_err is 0 for all legal modes. o_bit_idx is 0 for all non-BIT modes.
- SP rules:
  - SP updates only on accepted PUSH/POP, or on i_sp_wr.
  - Back-to-back PUSH/POP chain correctly because each request sees the SP updated by the previous accept.
  - i_sp_wr in the same cycle as an accepted PUSH/POP: the request uses the old SP for its address; SP takes i_sp_wdata (the write wins).
  - o_sp_q reflects the registered SP.
- Backpressure: a request is not accepted while o_req_ready=0. SP must not change for unaccepted PUSH/POP requests.

Test Plan:
- Reset, then check SP and REG mode: after reset o_sp_q=8'h07, o_addr_valid=0. REG with i_rs=2, i_rn=5 -> one cycle later o_addr=16'h0015, o_space=0.
- PUSH chain: three back-to-back PUSH with i_addr_ready=1 -> addresses 08, 09, 0A on consecutive cycles; SP ends at 8'h0A. Then POP -> address 0A, SP=09.
- Wrap: CODE_DPTR with DPTR=16'hFFF0, A=8'h20 -> o_addr=16'h0010, space 3. PUSH with SP=8'hFF -> address 00, SP=00.
- Bit addressing: BIT with i_direct=8'h2B -> address 16'h0025, bit_idx=3, space 0. BIT with i_direct=8'hD7 -> address 16'h00D0, bit_idx=7, space 1.
- Backpressure: i_addr_ready=0 for 3 cycles with PUSH held valid -> o_req_ready=0, outputs stable, SP unchanged. Raising i_addr_ready -> the PUSH is accepted once and SP increments exactly once.
- Collision and illegal mode: accepted POP at SP=8'h30 with i_sp_wr=1, wdata=8'h50 -> address 8'h30, SP=8'h50. Mode 12 -> o_err=1, address 0, SP unchanged. Assert i_rst while an entry is valid -> next cycle valid=0, SP=8'h07.
